// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC redirect controller.
// Holds the redirect FSM encoding and the JALR target alignment mask.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } redir_state_t;

    localparam int          PC_W_DEFAULT    = 9;
    // JALR clears bit 0 of rs1+imm before it becomes the target.
    localparam logic [31:0] JALR_ALIGN_MASK = 32'hFFFF_FFFE;

endpackage

// File: rtl/pc_redirect_ctrl.sv
// Next-PC selection and pipeline flush sequencing for JAL, JALR and taken branches.
// Parks a redirect that arrives under a fetch stall, then counts flush bubbles after it.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W      = PC_W_DEFAULT,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic             ex_br_taken,
    input  logic [PC_W-1:0]  ex_pc_target,
    input  logic [31:0]      ex_alu_result,
    input  logic [PC_W-1:0]  pc_plus4,
    input  logic             if_stall,
    output logic [PC_W-1:0]  pc_next,
    output logic             pc_we,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             redirect_busy,
    output logic             misalign,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam int              FC_W       = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0] FLUSH_INIT = FC_W'(FLUSH_CYC - 1);

    redir_state_t     state_reg, state_next;
    logic [PC_W-1:0]  tgt_q_reg, tgt_q_next;
    logic [FC_W-1:0]  flush_cnt_reg, flush_cnt_next;
    logic [CNT_W-1:0] redirect_cnt_reg;
    logic             cnt_inc;

    logic             req;
    logic [31:0]      alu_masked;
    logic [PC_W-1:0]  tgt;
    logic             unused_alu_hi;

    logic [PC_W-1:0]  pc_sel;
    logic             we_raw;
    logic             flush_ifid_raw;
    logic             flush_idex_raw;
    logic             misalign_raw;

    assign req           = ex_valid & (ex_is_jal | ex_is_jalr | ex_br_taken);
    assign alu_masked    = ex_alu_result & JALR_ALIGN_MASK;
    assign tgt           = ex_is_jalr ? alu_masked[PC_W-1:0] : ex_pc_target;
    // Upper ALU bits fall off: targets wrap modulo 2^PC_W.
    assign unused_alu_hi = ^alu_masked[31:PC_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= RUN;
            tgt_q_reg        <= '0;
            flush_cnt_reg    <= '0;
            redirect_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            tgt_q_reg     <= tgt_q_next;
            flush_cnt_reg <= flush_cnt_next;
            if (cnt_inc && (redirect_cnt_reg != {CNT_W{1'b1}})) begin
                redirect_cnt_reg <= redirect_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        tgt_q_next     = tgt_q_reg;
        flush_cnt_next = flush_cnt_reg;
        cnt_inc        = 1'b0;
        pc_sel         = pc_plus4;
        we_raw         = ~if_stall;
        flush_ifid_raw = 1'b0;
        flush_idex_raw = 1'b0;
        misalign_raw   = 1'b0;

        case (state_reg)
            RUN: begin
                if (req && tgt[1]) begin
                    misalign_raw = 1'b1;
                end else if (req && !if_stall) begin
                    pc_sel         = tgt;
                    we_raw         = 1'b1;
                    flush_ifid_raw = 1'b1;
                    flush_idex_raw = 1'b1;
                    cnt_inc        = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_next     = FLUSH;
                        flush_cnt_next = FLUSH_INIT;
                    end
                end else if (req) begin
                    // Kill the wrong-path instruction in ID now; PC waits for the stall.
                    tgt_q_next     = tgt;
                    flush_idex_raw = 1'b1;
                    we_raw         = 1'b0;
                    state_next     = HOLD;
                end
            end

            HOLD: begin
                pc_sel = tgt_q_reg;
                we_raw = 1'b0;
                if (!if_stall) begin
                    we_raw         = 1'b1;
                    flush_ifid_raw = 1'b1;
                    cnt_inc        = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_next     = FLUSH;
                        flush_cnt_next = FLUSH_INIT;
                    end else begin
                        state_next = RUN;
                    end
                end
            end

            FLUSH: begin
                flush_ifid_raw = 1'b1;
                if (!if_stall) begin
                    flush_cnt_next = flush_cnt_reg - 1'b1;
                    // The redirect cycle itself is the first of the FLUSH_CYC bubbles.
                    if (flush_cnt_reg == FC_W'(1)) begin
                        state_next = RUN;
                    end
                end
            end

            default: begin
                state_next     = RUN;
                flush_cnt_next = '0;
            end
        endcase
    end

    // Reset forces every output low, including the combinational ones.
    assign pc_next       = reset ? '0 : pc_sel;
    assign pc_we         = ~reset & we_raw;
    assign flush_ifid    = ~reset & flush_ifid_raw;
    assign flush_idex    = ~reset & flush_idex_raw;
    assign misalign      = ~reset & misalign_raw;
    assign redirect_busy = ~reset & (state_reg != RUN);
    assign redirect_cnt  = reset ? '0 : redirect_cnt_reg;

endmodule
